udp_loopback_buf: RTL and testbench



---
 rtl/udp_loopback_buf_if.sv | 22 ++
 rtl/udp_loopback_buf.sv | 178 +++++++++++++++++
 tb/tb_udp_loopback_buf.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_loopback_buf_if.sv
// UDP user-side stream bundle between the Ethernet control stage (master)
// and a user block such as the loopback buffer (slave).
interface udp_loopback_buf_if;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_data_vld;
  logic        udp_rx_done;
  logic [15:0] udp_rx_data_num;
  logic        udp_tx_en;
  logic [15:0] udp_tx_data_num;
  logic        udp_tx_req;
  logic [7:0]  udp_tx_data;

  modport master (
    output udp_rx_data, udp_rx_data_vld, udp_rx_done, udp_rx_data_num, udp_tx_req,
    input  udp_tx_en, udp_tx_data_num, udp_tx_data
  );

  modport slave (
    input  udp_rx_data, udp_rx_data_vld, udp_rx_done, udp_rx_data_num, udp_tx_req,
    output udp_tx_en, udp_tx_data_num, udp_tx_data
  );
endinterface

// File: rtl/udp_loopback_buf.sv
// UDP echo buffer: stores one received payload in a DEPTH x 8 RAM and replays
// it through the UDP transmit request interface.
// Optional macro UDP_LB_DROP_CNT_EN adds a saturating drop counter and an
// overflow sticky flag.
module udp_loopback_buf #(
  parameter int DEPTH      = 1472,
  parameter int AW         = 11,
  parameter int TX_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  udp_loopback_buf_if.slave udp,
  output logic              busy,
  output logic              drop_pulse
`ifdef UDP_LB_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic              ovf_sticky
`endif
);

  localparam int            RAW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] DEPTH_C  = AW'(DEPTH);
  localparam logic [15:0]   TMO_LAST = 16'(TX_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_START, S_SEND} state_t;

  state_t        r_state;
  logic [AW-1:0] r_wr_cnt;
  logic [AW-1:0] r_rd_ptr;
  logic          r_ovf;
  logic          r_skip;      // rest of a frame that began while busy is discarded
  logic          r_req_seen;
  logic          r_tx_en;
  logic          r_drop;
  logic [15:0]   r_tx_num;
  logic [15:0]   r_tmo;
  logic [7:0]    r_tx_data;
  logic [7:0]    r_mem [DEPTH];

  logic          w_we;
  logic [RAW-1:0] w_waddr;
  logic          w_rd_ok;
  logic          w_all_read;
  logic          w_ovf_drop;

  // Write-port decode and read-accept qualification
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    if (r_state == S_IDLE && udp.udp_rx_data_vld && !udp.udp_rx_done && !r_skip) begin
      w_we    = 1'b1;
      w_waddr = '0;
    end else if (r_state == S_RECV && udp.udp_rx_data_vld && !udp.udp_rx_done &&
                 r_wr_cnt != DEPTH_C) begin
      w_we    = 1'b1;
      w_waddr = r_wr_cnt[RAW-1:0];
    end
    w_all_read = (16'(r_rd_ptr) == r_tx_num);
    w_rd_ok    = (r_state == S_SEND) && udp.udp_tx_req && !w_all_read;
    w_ovf_drop = (r_state == S_RECV) && udp.udp_rx_done && r_ovf;
  end

  // Payload RAM write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= udp.udp_rx_data;
  end

  // Control FSM with registered outputs and registered RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wr_cnt   <= '0;
      r_rd_ptr   <= '0;
      r_ovf      <= 1'b0;
      r_skip     <= 1'b0;
      r_req_seen <= 1'b0;
      r_tx_en    <= 1'b0;
      r_drop     <= 1'b0;
      r_tx_num   <= '0;
      r_tmo      <= '0;
      r_tx_data  <= '0;
    end else begin
      r_tx_en <= 1'b0;
      r_drop  <= 1'b0;
      if (w_rd_ok) r_tx_data <= r_mem[r_rd_ptr[RAW-1:0]];

      // Frames arriving during START/SEND are discarded, one drop per done
      if (r_state == S_START || r_state == S_SEND) begin
        if (udp.udp_rx_done) begin
          r_drop <= 1'b1;
          r_skip <= 1'b0;
        end else if (udp.udp_rx_data_vld) begin
          r_skip <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (udp.udp_rx_done) begin
            r_drop <= 1'b1;
            r_skip <= 1'b0;
          end else if (udp.udp_rx_data_vld && !r_skip) begin
            r_wr_cnt <= AW'(1);
            r_ovf    <= 1'b0;
            r_state  <= S_RECV;
          end
        end
        S_RECV: begin
          if (udp.udp_rx_done) begin
            if (r_ovf || udp.udp_rx_data_num != 16'(r_wr_cnt) || r_wr_cnt == '0) begin
              r_drop  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_tx_num <= 16'(r_wr_cnt);
              r_tx_en  <= 1'b1;
              r_state  <= S_START;
            end
          end else if (udp.udp_rx_data_vld) begin
            if (r_wr_cnt == DEPTH_C) r_ovf <= 1'b1;
            else                     r_wr_cnt <= r_wr_cnt + AW'(1);
          end
        end
        S_START: begin
          // udp_tx_en is high during this cycle, so one cycle has already elapsed
          r_rd_ptr   <= '0;
          r_tmo      <= 16'd1;
          r_req_seen <= 1'b0;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_rd_ok) begin
            r_rd_ptr   <= r_rd_ptr + AW'(1);
            r_req_seen <= 1'b1;
          end
          if (w_all_read) begin
            // last byte is on udp_tx_data this cycle
            r_state <= S_IDLE;
          end else if (!r_req_seen && !udp.udp_tx_req) begin
            if (r_tmo == TMO_LAST) begin
              r_drop  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_tmo <= r_tmo + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign udp.udp_tx_en       = r_tx_en;
  assign udp.udp_tx_data_num = r_tx_num;
  assign udp.udp_tx_data     = r_tx_data;
  assign busy                = (r_state != S_IDLE);
  assign drop_pulse          = r_drop;

`ifdef UDP_LB_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  logic        r_ovf_sticky;

  // Saturating drop statistics, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt   <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (r_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (w_ovf_drop) r_ovf_sticky <= 1'b1;
    end
  end

  assign drop_cnt   = r_drop_cnt;
  assign ovf_sticky = r_ovf_sticky;
`endif

endmodule

// File: tb/tb_udp_loopback_buf.sv
// Self-checking bench for udp_loopback_buf (DEPTH=8, TX_TIMEOUT=16 build).
module tb_udp_loopback_buf;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, drop_pulse;
`ifdef UDP_LB_DROP_CNT_EN
  logic [15:0] drop_cnt;
  logic        ovf_sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  udp_loopback_buf_if u_if();

  udp_loopback_buf #(.DEPTH(8), .AW(4), .TX_TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .udp        (u_if.slave),
    .busy       (busy),
    .drop_pulse (drop_pulse)
`ifdef UDP_LB_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt),
    .ovf_sticky (ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n bytes base+i*step, then done with length num; samples drop/tx_en
  // in the cycle after done.
  task automatic send_frame(input int n, input int num, input logic [7:0] base,
                            input logic [7:0] step, output logic o_drop, output logic o_txen);
    for (int i = 0; i < n; i++) begin
      u_if.udp_rx_data     = base + 8'(i) * step;
      u_if.udp_rx_data_vld = 1'b1;
      tick();
    end
    u_if.udp_rx_data_vld = 1'b0;
    tick();
    u_if.udp_rx_done     = 1'b1;
    u_if.udp_rx_data_num = 16'(num);
    tick();
    u_if.udp_rx_done     = 1'b0;
    o_drop = drop_pulse;
    o_txen = u_if.udp_tx_en;
  endtask

  task automatic push_frame(input int n, input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 8'(i) * step);
  endtask

  // Issues n requests and compares each byte one cycle after its request.
  task automatic serve(input int n, input bit b2b, input string name);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      u_if.udp_tx_req = 1'b1;
      tick();
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_sb: got %h, scoreboard empty", name, u_if.udp_tx_data);
      end else begin
        e = exp_q.pop_front();
        if (u_if.udp_tx_data !== e) begin
          n_fail++;
          $display("FAIL %s_byte%0d: got %h, expected %h", name, i, u_if.udp_tx_data, e);
        end
      end
      if (!b2b) begin
        u_if.udp_tx_req = 1'b0;
        tick();
      end
    end
    if (b2b) begin
      u_if.udp_tx_req = 1'b0;
      tick();
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy_end: got %b, expected 0", name, busy);
    end
  endtask

  task automatic check_tx_start(input logic drop, input logic txen, input logic [15:0] num,
                                input string name);
    n_checks++;
    if (txen !== 1'b1 || drop !== 1'b0 || u_if.udp_tx_data_num !== num) begin
      n_fail++;
      $display("FAIL %s_start: tx_en=%b drop=%b num=%0d, expected tx_en=1 drop=0 num=%0d",
               name, txen, drop, u_if.udp_tx_data_num, num);
    end
    tick();
    n_checks++;
    if (u_if.udp_tx_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_txen_width: tx_en=%b busy=%b, expected tx_en=0 busy=1",
               name, u_if.udp_tx_en, busy);
    end
  endtask

  task automatic check_dropped(input logic drop, input logic txen, input string name);
    n_checks++;
    if (drop !== 1'b1 || txen !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drop: drop=%b tx_en=%b, expected drop=1 tx_en=0", name, drop, txen);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || drop_pulse !== 1'b0 || u_if.udp_tx_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after: busy=%b drop=%b tx_en=%b, expected all 0",
               name, busy, drop_pulse, u_if.udp_tx_en);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (u_if.udp_tx_en !== 1'b0 || u_if.udp_tx_data_num !== 16'd0 ||
        u_if.udp_tx_data !== 8'd0 || busy !== 1'b0 || drop_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: tx_en=%b num=%0d data=%h busy=%b drop=%b, expected all 0",
               name, u_if.udp_tx_en, u_if.udp_tx_data_num, u_if.udp_tx_data, busy, drop_pulse);
    end
`ifdef UDP_LB_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd0 || ovf_sticky !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_stats: drop_cnt=%0d ovf_sticky=%b, expected 0 0", name, drop_cnt, ovf_sticky);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_idle_outputs("reset");
  endtask

  task automatic test_single();
    logic d, t;
    push_frame(4, 8'h11, 8'h11);
    send_frame(4, 4, 8'h11, 8'h11, d, t);
    check_tx_start(d, t, 16'd4, "single");
    serve(4, 1'b1, "single");
    // request in IDLE is ignored and the last byte holds
    u_if.udp_tx_req = 1'b1;
    tick();
    u_if.udp_tx_req = 1'b0;
    tick();
    n_checks++;
    if (u_if.udp_tx_data !== 8'h44) begin
      n_fail++;
      $display("FAIL single_hold: got %h, expected 44", u_if.udp_tx_data);
    end
  endtask

  task automatic test_overflow();
    logic d, t;
    send_frame(10, 10, 8'h01, 8'h01, d, t);
    check_dropped(d, t, "overflow");
`ifdef UDP_LB_DROP_CNT_EN
    n_checks++;
    if (drop_cnt !== 16'd1 || ovf_sticky !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_stats: drop_cnt=%0d ovf_sticky=%b, expected 1 1", drop_cnt, ovf_sticky);
    end
`endif
  endtask

  task automatic test_mismatch();
    logic d, t;
    send_frame(5, 6, 8'h30, 8'h01, d, t);
    check_dropped(d, t, "mismatch");
  endtask

  task automatic test_busy_drop();
    logic d, t;
    push_frame(3, 8'h01, 8'h01);
    send_frame(3, 3, 8'h01, 8'h01, d, t);
    check_tx_start(d, t, 16'd3, "busy1");
    send_frame(3, 3, 8'hE0, 8'h01, d, t);
    n_checks++;
    if (d !== 1'b1 || t !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_drop: drop=%b tx_en=%b busy=%b, expected 1 0 1", d, t, busy);
    end
    serve(3, 1'b1, "busy1");
  endtask

  task automatic test_timeout();
    logic d, t;
    int cyc;
    send_frame(2, 2, 8'h77, 8'h01, d, t);
    check_tx_start(d, t, 16'd2, "tmo");
    cyc = 1;
    while (drop_pulse !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_checks++;
    if (cyc != 16 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: drop after %0d cycles busy=%b, expected 16 cycles busy=0", cyc, busy);
    end
    tick();
    push_frame(2, 8'hAA, 8'h11);
    send_frame(2, 2, 8'hAA, 8'h11, d, t);
    check_tx_start(d, t, 16'd2, "after_tmo");
    serve(2, 1'b0, "after_tmo");
  endtask

  task automatic test_reset_mid();
    logic d, t;
    int txen_seen;
    for (int i = 0; i < 3; i++) begin
      u_if.udp_rx_data     = 8'hC0 + 8'(i);
      u_if.udp_rx_data_vld = 1'b1;
      tick();
    end
    u_if.udp_rx_data_vld = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_outputs("reset_mid");
    txen_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (u_if.udp_tx_en !== 1'b0 || drop_pulse !== 1'b0) txen_seen++;
    end
    n_checks++;
    if (txen_seen != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: %0d cycles with tx_en/drop, expected 0", txen_seen);
    end
    push_frame(1, 8'h5A, 8'h00);
    send_frame(1, 1, 8'h5A, 8'h00, d, t);
    check_tx_start(d, t, 16'd1, "reset_mid");
    serve(1, 1'b0, "reset_mid");
  endtask

  initial begin
    u_if.udp_rx_data     = '0;
    u_if.udp_rx_data_vld = 1'b0;
    u_if.udp_rx_done     = 1'b0;
    u_if.udp_rx_data_num = '0;
    u_if.udp_tx_req      = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_mismatch();
    test_busy_drop();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d bytes remain, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
